// File: rtl/mul_temporal_ctrl_if.sv
//==============================================================================
// Module      : mul_temporal_ctrl_if
// Description : Operand, PE-row and completion signals of mul_temporal_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mul_temporal_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int LW    = 4
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data_x;
    logic [WIDTH-1:0] i_data_w;
    logic [LW-1:0]    i_len_log2;
    logic             o_bit_i;
    logic [WIDTH-2:0] o_randW;
    logic [WIDTH-2:0] o_data_w;
    logic             o_sign;
    logic             o_bit_vld;
    logic             o_first;
    logic             o_last;
    logic             o_done_vld;
    logic             i_done_rdy;
    logic             o_busy;

    modport master (
        output i_valid, i_data_x, i_data_w, i_len_log2, i_done_rdy,
        input  o_ready, o_bit_i, o_randW, o_data_w, o_sign, o_bit_vld,
               o_first, o_last, o_done_vld, o_busy
    );

    modport slave (
        input  i_valid, i_data_x, i_data_w, i_len_log2, i_done_rdy,
        output o_ready, o_bit_i, o_randW, o_data_w, o_sign, o_bit_vld,
               o_first, o_last, o_done_vld, o_busy
    );
endinterface

`default_nettype wire

// File: rtl/mul_temporal_ctrl.sv
//==============================================================================
// Module      : mul_temporal_ctrl
// Description : Sequencer for a row of unary-temporal multiply PEs. Optional
//               MUL_TEMPORAL_ZERO_SKIP_EN skips the run for zero operands.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mul_temporal_ctrl #(
    parameter int WIDTH = 16,
    parameter int LW    = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mul_temporal_ctrl_if.slave bus
);
    localparam int MW = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] w_k_nxt;
    logic [WIDTH-1:0] w_k_inc;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] w_n_in;
    logic [LW-1:0]    w_l_in;
    logic [LW-1:0]    w_shift;
    logic [MW-1:0]    w_mx_in;
    logic [MW-1:0]    r_mx;
    logic [MW-1:0]    w_k_inc_rev;
    logic [MW-1:0]    r_data_w;
    logic             r_sign;
    logic             w_accept;

    logic [MW-1:0]    r_randW;
    logic [MW-1:0]    w_randW_nxt;
    logic             r_bit_i;
    logic             w_bit_nxt;
    logic             r_bit_vld;
    logic             w_vld_nxt;
    logic             r_first;
    logic             w_first_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;

    // Run length clamped to 1..MW so the shift and N stay in range.
    always_comb begin
        if (bus.i_len_log2 == '0) begin
            w_l_in = LW'(1);
        end else if (bus.i_len_log2 > LW'(MW)) begin
            w_l_in = LW'(MW);
        end else begin
            w_l_in = bus.i_len_log2;
        end
    end

    assign w_shift  = LW'(MW) - w_l_in;
    assign w_n_in   = WIDTH'(1) << w_l_in;
    assign w_mx_in  = bus.i_data_x[MW-1:0] >> w_shift;
    assign w_k_inc  = r_k + WIDTH'(1);
    assign w_accept = (r_state == S_IDLE) && r_ready && bus.i_valid;

    generate
        for (genvar gi = 0; gi < MW; gi++) begin : g_bitrev
            assign w_k_inc_rev[gi] = w_k_inc[MW-1-gi];
        end
    endgenerate

    // Outputs are computed for the cycle after the edge and then registered.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_randW_nxt = '0;
        w_bit_nxt   = 1'b0;
        w_vld_nxt   = 1'b0;
        w_first_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_RUN;
`ifdef MUL_TEMPORAL_ZERO_SKIP_EN
                    if ((w_mx_in == '0) || (bus.i_data_w[MW-1:0] == '0)) begin
                        w_state_nxt = S_DONE;
                    end
`endif
                end
            end
            S_RUN: begin
                if (r_k == r_n) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_k_nxt     = w_k_inc;
                    w_vld_nxt   = 1'b1;
                    w_bit_nxt   = (r_k < {1'b0, r_mx});
                    w_first_nxt = (r_k == '0);
                    w_last_nxt  = (w_k_inc == r_n);
                    w_randW_nxt = (w_k_inc == r_n) ? '0 : w_k_inc_rev;
                end
            end
            S_DONE: begin
                if (bus.i_done_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_n       <= '0;
            r_mx      <= '0;
            r_data_w  <= '0;
            r_sign    <= 1'b0;
            r_randW   <= '0;
            r_bit_i   <= 1'b0;
            r_bit_vld <= 1'b0;
            r_first   <= 1'b0;
            r_last    <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_k       <= w_k_nxt;
            r_randW   <= w_randW_nxt;
            r_bit_i   <= w_bit_nxt;
            r_bit_vld <= w_vld_nxt;
            r_first   <= w_first_nxt;
            r_last    <= w_last_nxt;
            r_ready   <= (w_state_nxt == S_IDLE);
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_n      <= w_n_in;
                r_mx     <= w_mx_in;
                r_data_w <= bus.i_data_w[MW-1:0];
                r_sign   <= bus.i_data_x[MW] ^ bus.i_data_w[MW];
            end
        end
    end

    assign bus.o_ready    = r_ready;
    assign bus.o_busy     = r_busy;
    assign bus.o_done_vld = r_done;
    assign bus.o_randW    = r_randW;
    assign bus.o_bit_i    = r_bit_i;
    assign bus.o_bit_vld  = r_bit_vld;
    assign bus.o_first    = r_first;
    assign bus.o_last     = r_last;
    assign bus.o_data_w   = r_data_w;
    assign bus.o_sign     = r_sign;

endmodule

`default_nettype wire

// File: doc/mul_temporal_ctrl.md
Name: mul_temporal_ctrl

Overview:
- Sequencer for one row of unary-temporal multiply PEs.
- Each PE ANDs a temporal input bit with (weight > registered random number), and forwards its random number to the next PE through a one-cycle register.
- Per multiply, this block:
  - accepts one sign-magnitude activation/weight pair;
  - generates the temporal activation bitstream and the low-discrepancy weight random sequence;
  - frames the valid window for the downstream accumulator;
  - handshakes completion.
- Supports early termination via a run-length of 2^L cycles.

Parameters:
- WIDTH, 16, operand width incl. sign bit; magnitude is WIDTH-1 bits.
- LW, 4, width of i_len_log2; must satisfy 2^LW > WIDTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_valid  in  1  operand pair valid.
- o_ready  out  1  block can accept a pair.
- i_data_x  in  WIDTH  activation; MSB is sign, rest is magnitude.
- i_data_w  in  WIDTH  weight; MSB is sign, rest is magnitude.
- i_len_log2  in  LW  run length L; cycles N = 2^L.
- o_bit_i  out  1  temporal activation bit to PE row.
- o_randW  out  WIDTH-1  random number to first PE.
- o_data_w  out  WIDTH-1  latched weight magnitude.
- o_sign  out  1  product sign.
- o_bit_vld  out  1  o_bit_i/PE output bits valid this cycle.
- o_first  out  1  first valid bit cycle.
- o_last  out  1  last valid bit cycle.
- o_done_vld  out  1  multiply complete.
- i_done_rdy  in  1  downstream accepts completion.
- o_busy  out  1  not in IDLE.

Behaviour:
- Reset (rst=1 at posedge): state IDLE. All outputs 0, including o_ready, o_randW, o_data_w, o_sign and the counter. Reset in any state aborts immediately; no o_done_vld is issued.
- Length rule: the L register is latched at accept.
  - L = 0 is clamped to 1; L > WIDTH-1 is clamped to WIDTH-1.
  - N = 2^L; shift S = WIDTH-1-L.
- Latched at accept:
  - mx = |x| >> S
  - o_data_w = |w|
  - o_sign = x[MSB] ^ w[MSB]
- State IDLE:
  - o_ready = 1, o_busy = 0.
  - On i_valid & o_ready: latch operands, counter k = 0, go to RUN.
  - i_valid while not ready is ignored; the upstream holds its data.
- State RUN: lasts N+1 cycles, k = 0..N.
  - o_randW = bitrev_{WIDTH-1}(k) for k < N, and 0 at k = N (van der Corput; its first 2^L terms cover the range evenly).
  - Alignment with the PE's randW register: o_bit_i lags o_randW by one cycle.
    - k = 0 is a priming cycle: o_bit_vld = 0, o_bit_i = 0.
    - For k = 1..N: o_bit_vld = 1 and o_bit_i = ((k-1) < mx).
  - o_first = (k == 1); o_last = (k == N). When N = 2, o_first and o_last are in different cycles.
  - After k = N, go to DONE.
  - o_ready = 0.
- State DONE:
  - o_done_vld = 1; o_data_w and o_sign are held.
  - On i_done_rdy, go to IDLE; o_ready is 1 in the following cycle. There is no same-cycle accept from DONE.
  - If i_done_rdy is low, hold indefinitely.
- Latency: accept at cycle t → first o_bit_vld at t+2 → o_last at t+1+N → o_done_vld from t+2+N.
- Counter width: WIDTH bits, so k = N = 2^(WIDTH-1) is representable without wrap.
- o_randW, o_bit_i, o_bit_vld, o_first and o_last are all registered outputs.

Optional Feature:
- Macro MUL_TEMPORAL_ZERO_SKIP_EN.
- Defined: if latched mx == 0 or |w| == 0:
  - IDLE goes directly to DONE on the cycle after accept.
  - No o_bit_vld pulses; o_randW stays 0.
  - Completion latency is 1 cycle.
- Undefined: zero operands run the full N+1-cycle RUN with o_bit_i = 0 throughout.

Test Plan (WIDTH=16):
- Reset then idle: hold rst 3 cycles, release → all outputs 0 during reset; o_ready = 1 from the first cycle after release.
- Short run: x = 0x3000, w = 0x4000, L = 4, i_done_rdy = 1 →
  - 16 o_bit_vld cycles; o_bit_i = 1 on exactly the first 6 (0x3000 >> 11 = 6).
  - o_randW at k = 0..3 = 0x0000, 0x4000, 0x2000, 0x6000.
  - o_done_vld 1 cycle after o_last; o_sign = 0.
- Full run and sign: x = 0x8005 (−5), w = 0x0001, L = 15 →
  - 32768 valid cycles; o_bit_i = 1 on exactly 5 of them.
  - o_sign = 1; o_first and o_last each pulse once.
- Done backpressure: L = 1, i_done_rdy held 0 for 10 cycles → o_done_vld stays 1 and o_ready stays 0; i_done_rdy = 1 → IDLE, o_ready = 1 in the next cycle.
- Clamp and abort:
  - L = 0 → behaves as L = 1 (2 valid cycles).
  - L = 15 run with rst asserted at k = 100 → next cycle IDLE, all outputs 0, no o_done_vld.
- Zero skip: x = 0x0000, w = 0x1234, L = 4 →
  - With MUL_TEMPORAL_ZERO_SKIP_EN: o_done_vld 1 cycle after accept, no o_bit_vld.
  - Without it: 16 valid cycles, all o_bit_i = 0.
